// File: rtl/cache_16_ctrl_pkg.sv
// Shared definitions for the cache_16 miss/fill controller: FSM states,
// address field positions and the is_load_bus bit map.
package cache_16_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOOKUP = 3'd1,
    ST_FILL   = 3'd2,
    ST_WRITE  = 3'd3,
    ST_RESP   = 3'd4
  } state_t;

  // cpu_addr = {tag[4:3], idx[2], word[1:0]}
  localparam int TAG_HI  = 4;
  localparam int TAG_LO  = 3;
  localparam int IDX     = 2;
  localparam int WORD_HI = 1;
  localparam int WORD_LO = 0;

  localparam int LOAD_W0_I1 = 3;
  localparam int LOAD_W0_I0 = 2;
  localparam int LOAD_W1_I1 = 1;
  localparam int LOAD_W1_I0 = 0;

  function automatic logic [3:0] load_mask(input logic way, input logic idx);
    logic [3:0] m;
    m = 4'b0000;
    case ({way, idx})
      2'b00:   m[LOAD_W0_I0] = 1'b1;
      2'b01:   m[LOAD_W0_I1] = 1'b1;
      2'b10:   m[LOAD_W1_I0] = 1'b1;
      2'b11:   m[LOAD_W1_I1] = 1'b1;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/cache_16_ctrl_repl.sv
// Valid and LRU bookkeeping for the 2-way, 2-index cache, with victim select.
// lru[idx] names the way to evict next at that index.
module cache_repl
  import cache_16_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic idx,
  input  logic hit_en,
  input  logic hit_way,
  input  logic fill_en,
  output logic vld_w0,
  output logic vld_w1,
  output logic victim
);

  logic [3:0] valid;  // bit {way, idx}
  logic [1:0] lru;

  assign vld_w0 = valid[{1'b0, idx}];
  assign vld_w1 = valid[{1'b1, idx}];

  // prefer an empty way before falling back to LRU
  always_comb begin
    victim = 1'b0;
    if (!vld_w0) begin
      victim = 1'b0;
    end else if (!vld_w1) begin
      victim = 1'b1;
    end else begin
      victim = lru[idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 4'b0000;
      lru   <= 2'b00;
    end else if (fill_en) begin
      valid[{victim, idx}] <= 1'b1;
      lru[idx]             <= ~victim;
    end else if (hit_en) begin
      lru[idx] <= ~hit_way;
    end
  end

endmodule

// File: rtl/cache_16_ctrl.sv
// Read-only miss/fill controller for the cache_16 datapath. c_rdata carries
// the word cache_16 presents for the current tag/index/offset/way select.
module cache_16_ctrl
  import cache_16_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cpu_req,
  input  logic [4:0]         cpu_addr,
  output logic               cpu_ready,
  output logic               cpu_valid,
  output logic [WIDTH-1:0]   cpu_rdata,
  output logic               mem_req,
  output logic [4:0]         mem_addr,
  input  logic               mem_ack,
  input  logic [WIDTH-1:0]   mem_rdata,
  output logic [1:0]         c_tag,
  output logic               c_index,
  output logic [2:0]         c_offset,
  output logic               c_word_sel,
  output logic [3:0]         c_load,
  output logic [8*WIDTH-1:0] c_fill_bus,
  input  logic               c_hit,
  input  logic               c_hit_0,
  input  logic [WIDTH-1:0]   c_rdata,
  output logic [CNT_W-1:0]   hit_cnt,
  output logic [CNT_W-1:0]   miss_cnt
);

  state_t             state, next;
  logic [4:0]         areg;
  logic [1:0]         cnt;
  logic [WIDTH-1:0]   fill_buf [4];
  logic               refill;
  logic               vld_w0, vld_w1, victim, lookup_hit;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  assign c_tag      = areg[TAG_HI:TAG_LO];
  assign c_index    = areg[IDX];
  assign c_offset   = areg[IDX:WORD_LO];
  assign c_word_sel = c_hit_0;
  // the tag compare alone is not trusted: cache registers are never reset
  assign lookup_hit = c_hit & (c_hit_0 ? vld_w0 : vld_w1);
  assign cpu_ready  = (state == ST_IDLE);
  assign cpu_valid  = (state == ST_RESP);
  assign mem_req    = (state == ST_FILL);
  assign mem_addr   = {areg[TAG_HI:IDX], cnt};
  assign c_load     = (state == ST_WRITE) ? load_mask(victim, areg[IDX]) : 4'b0000;

  for (genvar w = 0; w < 4; w++) begin : g_fill
    assign c_fill_bus[w*WIDTH +: WIDTH]     = fill_buf[w];
    assign c_fill_bus[(w+4)*WIDTH +: WIDTH] = fill_buf[w];
  end

  cache_repl u_repl (
    .clk     (clk),
    .rst     (rst),
    .idx     (areg[IDX]),
    .hit_en  ((state == ST_LOOKUP) && lookup_hit),
    .hit_way (~c_hit_0),
    .fill_en (state == ST_WRITE),
    .vld_w0  (vld_w0),
    .vld_w1  (vld_w1),
    .victim  (victim)
  );

  always_comb begin
    next = state;
    case (state)
      ST_IDLE:   if (cpu_req) next = ST_LOOKUP; else next = ST_IDLE;
      ST_LOOKUP: if (lookup_hit) next = ST_RESP; else next = ST_FILL;
      ST_FILL:   if (mem_ack && (cnt == 2'd3)) next = ST_WRITE; else next = ST_FILL;
      ST_WRITE:  next = ST_LOOKUP;
      ST_RESP:   next = ST_IDLE;
      default:   next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      areg      <= 5'd0;
      cnt       <= 2'd0;
      refill    <= 1'b0;
      cpu_rdata <= '0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
      for (int i = 0; i < 4; i++) fill_buf[i] <= '0;
    end else begin
      state <= next;
      case (state)
        ST_IDLE: begin
          if (cpu_req) begin
            areg   <= cpu_addr;
            refill <= 1'b0;
          end
        end
        ST_LOOKUP: begin
          if (lookup_hit) begin
            cpu_rdata <= c_rdata;
            if (!refill && (hit_cnt != CNT_MAX)) hit_cnt <= hit_cnt + CNT_ONE;
          end else begin
            cnt <= 2'd0;
            if (!refill && (miss_cnt != CNT_MAX)) miss_cnt <= miss_cnt + CNT_ONE;
          end
        end
        ST_FILL: begin
          if (mem_ack) begin
            fill_buf[cnt] <= mem_rdata;
            cnt           <= cnt + 2'd1;
          end
        end
        ST_WRITE: refill <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_16_ctrl.sv
// Directed bench for cache_16_ctrl with a behavioural cache_16 model
// (tags and line data per way/index, captured from c_load/c_fill_bus).
module tb_cache_16_ctrl;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst, cpu_req, mem_ack;
  logic [4:0]     cpu_addr;
  logic [W-1:0]   mem_rdata;
  logic           cpu_ready, cpu_valid, mem_req;
  logic [W-1:0]   cpu_rdata, c_rdata;
  logic [4:0]     mem_addr;
  logic [1:0]     c_tag;
  logic           c_index, c_word_sel, c_hit, c_hit_0;
  logic [2:0]     c_offset;
  logic [3:0]     c_load;
  logic [8*W-1:0] c_fill_bus;
  logic [1:0]     hit_cnt, miss_cnt;

  int tests = 0;
  int fails = 0;

  logic [1:0]   mtag  [2][2];
  logic [W-1:0] mdata [2][2][4];
  logic [3:0]   last_load;
  int           load_pulses;
  int           mreq_cycles;
  logic         m0, m1;

  always #5 clk = ~clk;

  cache_16_ctrl #(.WIDTH(W), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
    .cpu_ready(cpu_ready), .cpu_valid(cpu_valid), .cpu_rdata(cpu_rdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .c_tag(c_tag), .c_index(c_index), .c_offset(c_offset), .c_word_sel(c_word_sel),
    .c_load(c_load), .c_fill_bus(c_fill_bus), .c_hit(c_hit), .c_hit_0(c_hit_0),
    .c_rdata(c_rdata), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  // cache_16 model: tag compare per way, word select by c_word_sel
  always_comb begin
    m0 = (mtag[0][c_index] == c_tag);
    m1 = (mtag[1][c_index] == c_tag);
    c_hit   = m0 | m1;
    c_hit_0 = m0;
    c_rdata = c_word_sel ? mdata[0][c_index][c_offset[1:0]] : mdata[1][c_index][c_offset[1:0]];
  end

  always @(posedge clk) begin
    if (rst) begin
      for (int a = 0; a < 2; a++)
        for (int b = 0; b < 2; b++) begin
          mtag[a][b] <= 2'b00;
          for (int c = 0; c < 4; c++) mdata[a][b][c] <= 32'hDEAD_BEEF;
        end
      last_load   <= 4'b0000;
      load_pulses <= 0;
      mreq_cycles <= 0;
    end else begin
      if (mem_req) mreq_cycles <= mreq_cycles + 1;
      if (c_load != 4'b0000) begin
        last_load   <= c_load;
        load_pulses <= load_pulses + 1;
      end
      for (int wy = 0; wy < 2; wy++)
        for (int ix = 0; ix < 2; ix++)
          if (c_load[(wy == 0 ? 2 : 0) + ix]) begin
            mtag[wy][ix] <= c_tag;
            for (int w = 0; w < 4; w++) mdata[wy][ix][w] <= c_fill_bus[(ix*4+w)*W +: W];
          end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic request(input logic [4:0] a);
    @(negedge clk);
    check("ready_before_req", {63'd0, cpu_ready}, 64'd1);
    cpu_req = 1'b1; cpu_addr = a;
    @(negedge clk);
    cpu_req = 1'b0;
  endtask

  task automatic wait_mreq();
    int n = 0;
    while (!mem_req && n < 8) begin @(negedge clk); n++; end
    check("mem_req_rise", {63'd0, mem_req}, 64'd1);
  endtask

  task automatic serve_fill(input logic [4:0] base, input logic [W-1:0] d, input int waits);
    wait_mreq();
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < waits; k++) begin
        check("wait_mem_req", {63'd0, mem_req}, 64'd1);
        check("wait_mem_addr", {59'd0, mem_addr}, {59'd0, base | 5'(i)});
        @(negedge clk);
      end
      check("fill_mem_addr", {59'd0, mem_addr}, {59'd0, base | 5'(i)});
      mem_ack = 1'b1; mem_rdata = d + W'(i);
      @(negedge clk);
      mem_ack = 1'b0;
    end
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!cpu_valid && n < 30) begin @(negedge clk); n++; end
    check("cpu_valid_seen", {63'd0, cpu_valid}, 64'd1);
  endtask

  initial begin
    int lp;
    int mq;
    rst = 1'b1; cpu_req = 1'b0; cpu_addr = 5'd0; mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", {63'd0, cpu_ready}, 64'd1);
    check("rst_valid", {63'd0, cpu_valid}, 64'd0);
    check("rst_rdata", {32'd0, cpu_rdata}, 64'd0);
    check("rst_mem_req", {63'd0, mem_req}, 64'd0);
    check("rst_c_load", {60'd0, c_load}, 64'd0);
    check("rst_hit_cnt", {62'd0, hit_cnt}, 64'd0);
    check("rst_miss_cnt", {62'd0, miss_cnt}, 64'd0);
    rst = 1'b0;

    // 1: cold miss
    request(5'b01_0_10);
    check("t1_lookup_no_valid", {63'd0, cpu_valid}, 64'd0);
    serve_fill(5'h08, 32'hA0A0_0000, 0);
    check("t1_c_load", {60'd0, c_load}, 64'b0100);
    wait_valid();
    check("t1_rdata", {32'd0, cpu_rdata}, 64'hA0A0_0002);
    check("t1_miss_cnt", {62'd0, miss_cnt}, 64'd1);
    check("t1_hit_cnt", {62'd0, hit_cnt}, 64'd0);
    check("t1_load_pulses", 64'(load_pulses), 64'd1);

    // 2: hit after fill
    mq = mreq_cycles;
    request(5'b01_0_11);
    check("t2_valid_c1", {63'd0, cpu_valid}, 64'd0);
    @(negedge clk);
    check("t2_valid_c2", {63'd0, cpu_valid}, 64'd1);
    check("t2_rdata", {32'd0, cpu_rdata}, 64'hA0A0_0003);
    check("t2_hit_cnt", {62'd0, hit_cnt}, 64'd1);
    @(negedge clk);
    check("t2_valid_one_cycle", {63'd0, cpu_valid}, 64'd0);
    check("t2_no_mem_req", 64'(mreq_cycles), 64'(mq));

    // 3: second tag same idx, then LRU eviction
    request(5'b10_0_00);
    serve_fill(5'h10, 32'hB0B0_0000, 0);
    wait_valid();
    check("t3a_c_load", {60'd0, last_load}, 64'b0001);
    check("t3a_rdata", {32'd0, cpu_rdata}, 64'hB0B0_0000);
    check("t3a_miss_cnt", {62'd0, miss_cnt}, 64'd2);
    request(5'b11_0_00);
    serve_fill(5'h18, 32'hC0C0_0000, 0);
    wait_valid();
    check("t3b_c_load", {60'd0, last_load}, 64'b0100);
    check("t3b_rdata", {32'd0, cpu_rdata}, 64'hC0C0_0000);
    check("t3b_miss_cnt", {62'd0, miss_cnt}, 64'd3);

    // 4: three wait cycles per word, idx 1
    request(5'b10_1_01);
    serve_fill(5'h14, 32'hD0D0_0000, 3);
    wait_valid();
    check("t4_c_load", {60'd0, last_load}, 64'b1000);
    check("t4_rdata", {32'd0, cpu_rdata}, 64'hD0D0_0001);
    check("t4_miss_sat", {62'd0, miss_cnt}, 64'd3);
    for (int i = 0; i < 4; i++)
      check("t4_word_order", {32'd0, mdata[0][1][i]}, {32'd0, 32'hD0D0_0000 + 32'(i)});

    // 6: hit counter saturation at 2'b11
    for (int i = 0; i < 5; i++) begin
      request(5'b10_0_01);
      @(negedge clk);
      check("t6_hit_valid", {63'd0, cpu_valid}, 64'd1);
      check("t6_hit_rdata", {32'd0, cpu_rdata}, 64'hB0B0_0001);
    end
    check("t6_hit_sat", {62'd0, hit_cnt}, 64'd3);

    // 5: reset during fill after two acks; model tag matches but line is invalid
    request(5'b00_1_00);
    wait_mreq();
    for (int i = 0; i < 2; i++) begin
      mem_ack = 1'b1; mem_rdata = 32'hE0E0_0000 + 32'(i);
      @(negedge clk);
      mem_ack = 1'b0;
    end
    lp = load_pulses;
    rst = 1'b1;
    @(negedge clk);
    check("t5_mem_req_drop", {63'd0, mem_req}, 64'd0);
    check("t5_ready", {63'd0, cpu_ready}, 64'd1);
    check("t5_no_c_load", {60'd0, c_load}, 64'd0);
    rst = 1'b0;
    request(5'b00_1_00);
    serve_fill(5'h04, 32'hF0F0_0000, 0);
    wait_valid();
    check("t5_remiss_cnt", {62'd0, miss_cnt}, 64'd1);
    check("t5_c_load", {60'd0, last_load}, 64'b1000);
    check("t5_rdata", {32'd0, cpu_rdata}, 64'hF0F0_0000);
    check("t5_hit_cnt", {62'd0, hit_cnt}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
